// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA writes queue bytes in a FIFO, STATUS reports full/empty/busy/overflow/count.
// Push-to-start-bit latency is one clock; a write to a full FIFO is dropped and flags a sticky overflow.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h4000_0000,
    parameter int          CLOCKS_PER_BIT  = 100,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic [31:0] data_out,
    input  logic        data_write,
    input  logic        data_read,
    output logic [31:0] data_in,
    output logic        tx,
    output logic        irq_empty
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int BW    = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [31:0]   TXDATA_ADDR = BASE_ADDRESS + 32'd4;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDRESS + 32'd12;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_d;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          overflow;
    logic [7:0]    sh, sh_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic          baud_wrap;
    logic          tx_d;
    logic          push_req, push, pop, full, empty, status_wr;
    logic          unused_ok;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign push_req  = data_write && (data_address == TXDATA_ADDR);
    assign status_wr = data_write && (data_address == STATUS_ADDR);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push      = push_req && (!full || pop);
    assign unused_ok = ^{data_read, data_out[31:8]};

    always_comb begin
        data_in = 32'h0;
        if (data_address == STATUS_ADDR) begin
            data_in[0]    = full;
            data_in[1]    = empty;
            data_in[2]    = (state != IDLE);
            data_in[3]    = overflow;
            data_in[15:8] = 8'(count);
        end
    end

    always_comb begin
        state_d   = state;
        sh_d      = sh;
        bit_cnt_d = bit_cnt;
        baud_d    = baud_cnt;
        pop       = 1'b0;
        tx_d      = 1'b1;
        baud_wrap = (baud_cnt == BAUD_LAST);
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sh_d      = mem[rd_ptr];
                    bit_cnt_d = 3'd0;
                    baud_d    = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d    = '0;
                    sh_d      = {1'b0, sh[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the upcoming state so it changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase

        count_d = count;
        if (push && !pop)      count_d = count + CW'(1);
        else if (pop && !push) count_d = count - CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh        <= 8'h0;
            bit_cnt   <= 3'd0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
            irq_empty <= 1'b1;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            sh        <= sh_d;
            bit_cnt   <= bit_cnt_d;
            baud_cnt  <= baud_d;
            tx        <= tx_d;
            irq_empty <= (count_d == '0) && (state_d == IDLE);
            count     <= count_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push_req && !push)
                overflow <= 1'b1;
            else if (status_wr && data_out[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_out[7:0];
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLOCKS_PER_BIT=4 and a 16-entry FIFO.
module tb_uart_tx_mmio;
    localparam int          CPB    = 4;
    localparam logic [31:0] TXDATA = 32'h4000_0004;
    localparam logic [31:0] STATUS = 32'h4000_000C;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_address;
    logic [31:0] data_out;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_in;
    logic        tx;
    logic        irq_empty;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_mmio #(
        .BASE_ADDRESS   (32'h4000_0000),
        .CLOCKS_PER_BIT (CPB),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_address(data_address),
        .data_out    (data_out),
        .data_write  (data_write),
        .data_read   (data_read),
        .data_in     (data_in),
        .tx          (tx),
        .irq_empty   (irq_empty)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] dat);
        data_address = addr;
        data_out     = dat;
        data_write   = 1'b1;
        @(posedge clock);
        #1;
        data_write   = 1'b0;
        data_address = 32'h0;
        data_out     = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
        data_address = addr;
        data_read    = 1'b1;
        #1;
        val          = data_in;
        data_read    = 1'b0;
        data_address = 32'h0;
    endtask

    // obs = {all bits held steady, stop, data[7:0], start}; obs=0 when no start bit appears in time.
    task automatic capture_frame(input int skip, input int max_wait,
                                 output logic [10:0] obs, output int waited);
        logic [9:0] bits;
        logic       stable;
        int         first;
        waited = 0;
        bits   = '1;
        stable = 1'b1;
        while (tx !== 1'b0 && waited < max_wait) begin
            step(1);
            waited++;
        end
        if (tx !== 1'b0) begin
            obs    = '0;
            waited = -1;
        end else begin
            for (int i = 0; i < 10; i++) begin
                first = (i == 0) ? skip : 0;
                for (int k = first; k < CPB; k++) begin
                    if (k == first) bits[i] = tx;
                    else if (tx !== bits[i]) stable = 1'b0;
                    step(1);
                end
            end
            obs = {stable, bits};
        end
    endtask

    task automatic test_reset;
        logic [31:0] st;
        reset        = 1'b1;
        data_address = 32'h0;
        data_out     = 32'h0;
        data_write   = 1'b0;
        data_read    = 1'b0;
        step(3);
        @(negedge clock);
        reset = 1'b0;
        step(1);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
        n_checks++;
        if (irq_empty !== 1'b1) $display("FAIL reset_irq: got %b expected 1", irq_empty); else n_pass++;
        data_address = STATUS;
        #1;
        st = data_in;
        data_address = 32'h0;
        n_checks++;
        if (st !== 32'h0000_0002) $display("FAIL reset_status: got %h expected 00000002", st); else n_pass++;
    endtask

    task automatic test_single_frame;
        logic [10:0] obs;
        int          w;
        bus_write(TXDATA, 32'hFFFF_FF55);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL single_write_cycle_tx: got %b expected 1", tx); else n_pass++;
        n_checks++;
        if (irq_empty !== 1'b0) $display("FAIL single_irq_busy: got %b expected 0", irq_empty); else n_pass++;
        capture_frame(0, 2, obs, w);
        n_checks++;
        if (w !== 1) $display("FAIL single_start_latency: got %0d expected 1", w); else n_pass++;
        n_checks++;
        if (obs !== {2'b11, 8'h55, 1'b0}) $display("FAIL single_frame_55: got %b expected %b", obs, {2'b11, 8'h55, 1'b0});
        else n_pass++;
        n_checks++;
        if (irq_empty !== 1'b1 || tx !== 1'b1)
            $display("FAIL single_after_frame: got irq=%b tx=%b expected irq=1 tx=1", irq_empty, tx);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] st;
        logic [10:0] obs;
        logic [7:0]  b;
        int          w;
        bus_write(TXDATA, 32'h41);
        bus_write(TXDATA, 32'h42);
        bus_write(TXDATA, 32'h43);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_0204) $display("FAIL b2b_status: got %h expected 00000204", st); else n_pass++;
        capture_frame(1, 0, obs, w);
        n_checks++;
        if (obs !== {2'b11, 8'h41, 1'b0}) $display("FAIL b2b_frame_41: got %b expected %b", obs, {2'b11, 8'h41, 1'b0});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            b = 8'h42 + 8'(i);
            capture_frame(0, 5, obs, w);
            n_checks++;
            if (w !== 1) $display("FAIL b2b_gap_%h: got %0d idle cycles expected 1", b, w); else n_pass++;
            n_checks++;
            if (obs !== {2'b11, b, 1'b0}) $display("FAIL b2b_frame_%h: got %b expected %b", b, obs, {2'b11, b, 1'b0});
            else n_pass++;
        end
        n_checks++;
        if (irq_empty !== 1'b1) $display("FAIL b2b_irq_end: got %b expected 1", irq_empty); else n_pass++;
    endtask

    task automatic test_overflow_and_full_pop;
        logic [31:0] st;
        logic [10:0] obs;
        logic [7:0]  b;
        int          w;
        logic        low_seen;
        bus_write(TXDATA, 32'hA0);
        for (int i = 1; i <= 16; i++) bus_write(TXDATA, 32'(i));
        bus_write(TXDATA, 32'h77);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_100D) $display("FAIL ovf_status: got %h expected 0000100D", st); else n_pass++;
        bus_write(STATUS, 32'h7);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_100D) $display("FAIL ovf_keep: got %h expected 0000100D", st); else n_pass++;
        bus_write(STATUS, 32'h8);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_1005) $display("FAIL ovf_clear: got %h expected 00001005", st); else n_pass++;

        w = 0;
        bus_read(STATUS, st);
        while (st[2] !== 1'b0 && w < 100) begin
            step(1);
            bus_read(STATUS, st);
            w++;
        end
        n_checks++;
        if (st !== 32'h0000_1001) $display("FAIL full_idle_status: got %h expected 00001001", st); else n_pass++;
        bus_write(TXDATA, 32'h99);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_1005) $display("FAIL full_push_pop: got %h expected 00001005", st); else n_pass++;

        for (int i = 1; i <= 17; i++) begin
            b = (i == 17) ? 8'h99 : 8'(i);
            capture_frame(0, (i == 1) ? 0 : 5, obs, w);
            n_checks++;
            if (w !== ((i == 1) ? 0 : 1)) $display("FAIL fill_gap_%h: got %0d idle cycles", b, w); else n_pass++;
            n_checks++;
            if (obs !== {2'b11, b, 1'b0}) $display("FAIL fill_frame_%h: got %b expected %b", b, obs, {2'b11, b, 1'b0});
            else n_pass++;
        end
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) low_seen = 1'b1;
            step(1);
        end
        n_checks++;
        if (low_seen !== 1'b0) $display("FAIL dropped_byte_sent: got tx activity expected idle"); else n_pass++;
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_0002 || irq_empty !== 1'b1)
            $display("FAIL fill_end_status: got %h irq=%b expected 00000002 irq=1", st, irq_empty);
        else n_pass++;
    endtask

    task automatic test_decode;
        logic [31:0] st;
        logic        low_seen;
        bus_read(TXDATA, st);
        n_checks++;
        if (st !== 32'h0) $display("FAIL read_txdata: got %h expected 00000000", st); else n_pass++;
        bus_read(32'h4000_0010, st);
        n_checks++;
        if (st !== 32'h0) $display("FAIL read_0010: got %h expected 00000000", st); else n_pass++;
        bus_write(32'h4000_0008, 32'hFF);
        bus_write(32'h4000_0000, 32'h41);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_0002) $display("FAIL write_0008_status: got %h expected 00000002", st); else n_pass++;
        low_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx !== 1'b1 || irq_empty !== 1'b1) low_seen = 1'b1;
            step(1);
        end
        n_checks++;
        if (low_seen !== 1'b0) $display("FAIL write_0008_idle: got activity expected idle"); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] st;
        logic        low_seen;
        bus_write(TXDATA, 32'h50);
        bus_write(TXDATA, 32'h11);
        bus_write(TXDATA, 32'h22);
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_0204) $display("FAIL mid_status_before: got %h expected 00000204", st); else n_pass++;
        step(16);
        n_checks++;
        if (tx !== 1'b0) $display("FAIL mid_data_bit3: got %b expected 0", tx); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || irq_empty !== 1'b1)
            $display("FAIL mid_async_reset: got tx=%b irq=%b expected tx=1 irq=1", tx, irq_empty);
        else n_pass++;
        bus_read(STATUS, st);
        n_checks++;
        if (st !== 32'h0000_0002) $display("FAIL mid_status_reset: got %h expected 00000002", st); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        n_checks++;
        if (low_seen !== 1'b0) $display("FAIL mid_no_frames_after: got tx activity expected idle"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow_and_full_pop();
        test_decode();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped debug UART transmitter on the core's data bus.
- Replaces the simulation-only character print at 0x4000_0004 with a real serial output.
- Bytes written by the core are queued in a FIFO and sent as 8N1 frames on tx.
- A status register lets firmware poll for space and idle.

Parameters:
BASE_ADDRESS, 32'h4000_0000, peripheral window base; TXDATA = BASE+4, STATUS = BASE+12.
CLOCKS_PER_BIT, 100, clock cycles per serial bit (>=2).
FIFO_DEPTH_LOG2, 4, FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
clock  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-high; clears all state immediately.
data_address  input  32  core data bus address.
data_out  input  32  core write data; only [7:0] used for TXDATA, [3] for STATUS.
data_write  input  1  write strobe, one cycle per access.
data_read  input  1  read strobe.
data_in  output  32  read data to core, combinational.
tx  output  1  serial line, idle high.
irq_empty  output  1  high while FIFO empty and transmitter idle.

Behaviour:
- Reset values: tx=1; FIFO empty (count 0, pointers 0); FSM=IDLE; overflow=0; irq_empty=1. data_in follows its equation: 0 unless STATUS is addressed.
- Reset mid-frame aborts the frame. tx returns to 1 asynchronously and the queued bytes are discarded.
- data_width is not connected. Any width of write to TXDATA pushes data_out[7:0].
- Push: data_write && address==TXDATA. Accepted if count<DEPTH before the edge, or if a pop happens in the same cycle. Otherwise the byte is dropped and overflow is set (sticky).
- STATUS write with data_out[3]=1 clears overflow. Other STATUS bits are read-only.
- STATUS read (address==STATUS; data_read not required):
  - [0] full
  - [1] empty
  - [2] busy (FSM != IDLE)
  - [3] overflow
  - [15:8] count, zero-extended
  - all other bits 0.
- Other addresses, including TXDATA, read as 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty at the edge, pop the head into shift register sh, bit_cnt=0, baud_cnt=0, go to START.
  - START: tx=0 for CLOCKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=sh[0], LSB first. Every CLOCKS_PER_BIT cycles shift sh right and increment bit_cnt. After 8 bits go to STOP.
  - STOP: tx=1 for CLOCKS_PER_BIT cycles, then go to IDLE.
- baud_cnt counts 0..CLOCKS_PER_BIT-1 and wraps at each bit boundary.
- tx is registered from the FSM state and sh; no combinational glitches.
- Latency: push accepted at edge N (count=1 after N). Pop and START at edge N+1, so tx=0 from N+1.
- Frame length is exactly 10*CLOCKS_PER_BIT cycles.
- Back-to-back frames: STOP -> IDLE -> START adds exactly one idle cycle between frames.
- FIFO pointers wrap modulo DEPTH. Count width is FIFO_DEPTH_LOG2+1.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
- Push to an empty FIFO in the same cycle the FSM is IDLE: no pop that cycle; the pop happens next edge.
- irq_empty = empty && FSM==IDLE, registered output.

Test Plan:
- Reset, CLOCKS_PER_BIT=4: write 0x55 to 0x4000_0004. tx is 1 for the write cycle, then reads 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles (start bit, data LSB first, stop bit). Total 40 cycles, then irq_empty=1.
- Write 0x41, 0x42, 0x43 on consecutive cycles. Frames appear in order with exactly one idle-high cycle between them. STATUS[15:8] reads 2 right after the third write (one byte already popped).
- Fill the FIFO (DEPTH=16) while a frame is in flight, then write once more:
  - STATUS reads full=1, overflow=1, count=16 (0x0000_100D).
  - Writing 0x8 to STATUS clears overflow.
  - The dropped byte is never transmitted.
- FIFO full, and a push arrives in the same cycle the FSM pops: the push is accepted, count stays 16, overflow stays 0.
- Assert reset asynchronously (mid-cycle) during DATA bit 3 with bytes queued. tx=1 immediately, STATUS reads 0x0000_0002, and no further frames appear after reset releases.
- Read 0x4000_0004 and 0x4000_0010: data_in=0. A write to 0x4000_0008 has no effect on the FIFO or STATUS.
